vga_sync_checker: RTL

VGA_SYNC_CHECKER -- requirements
Module: vga_sync_checker

---
 rtl/vga_sync_checker.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_checker.sv
// vga_sync_checker
// Watches an hsync/vsync pair, sampled on a pixel strobe, and checks it against
// the configured VGA timing. After two consecutive clean vsync edges it reports
// lock. It counts error-free frames. While locked, it reports every horizontal
// or vertical timing violation with a one-cycle pulse and a saturating error count.

module vga_sync_checker #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pix_en_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic        locked_o,
  output logic [15:0] frame_cnt_o,
  output logic        h_err_o,
  output logic        v_err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Each counter saturates at its total, so it needs room for the total itself.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_MAX       = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX       = VW'(V_TOTAL);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_SYNC - 1);

  localparam logic ACT_LVL = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;

  logic            hs_act, vs_act;
  logic            hs_prev_q, vs_prev_q;
  logic            h_rise, h_fall, v_rise, v_fall;

  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            h_viol, v_viol, viol;

  logic            frame_err_q, frame_err_d;
  logic            frame_inc, report;

  logic            locked_q;
  logic            h_err_q, v_err_q;
  logic [15:0]     frame_cnt_q;
  logic [7:0]      err_cnt_q;

  // Syncs are normalised to "active" booleans. An inactive history is therefore 0.
  assign hs_act = (hsync_i == ACT_LVL);
  assign vs_act = (vsync_i == ACT_LVL);

  assign h_rise = pix_en_i &  hs_act & ~hs_prev_q;
  assign h_fall = pix_en_i & ~hs_act &  hs_prev_q;
  assign v_rise = pix_en_i &  vs_act & ~vs_prev_q;
  assign v_fall = pix_en_i & ~vs_act &  vs_prev_q;

  // Remember the sync levels of the previous strobed sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // in the block sees pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else if (pix_en_i) begin
      hs_prev_q <= hs_act;
      vs_prev_q <= vs_act;
    end
  end

  // Next counter values and timing violations for the current sample.
  always_comb begin
    // NOTE: every signal gets a default before any branch; without one, a
    // path that skips an assignment would infer a latch.
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_viol  = 1'b0;
    v_viol  = 1'b0;

    if (pix_en_i) begin
      // A line must start exactly one sample after the previous line's last pixel.
      if (h_rise) begin
        h_cnt_d = '0;
        if (h_cnt_q != H_LAST) h_viol = 1'b1;
      end else if (h_cnt_q != H_MAX) begin
        h_cnt_d = h_cnt_q + 1'b1;
        // No hsync after H_TOTAL pixels: the line is too long.
        if (h_cnt_q == H_LAST) h_viol = 1'b1;
      end
      // The count includes the deasserting sample, so hsync was active for
      // exactly H_SYNC samples when the old count is H_SYNC-1.
      if (h_fall && (h_cnt_q != H_SYNC_LAST)) h_viol = 1'b1;

      // Lines are counted on hsync leading edges. vsync edges sit on line starts.
      if (v_rise) begin
        v_cnt_d = '0;
        if (v_cnt_q != V_LAST) v_viol = 1'b1;
      end else if (h_rise && (v_cnt_q != V_MAX)) begin
        v_cnt_d = v_cnt_q + 1'b1;
        if (v_cnt_q == V_LAST) v_viol = 1'b1;
      end
      if (v_fall && (v_cnt_q != V_SYNC_LAST)) v_viol = 1'b1;
    end
  end

  assign viol = h_viol | v_viol;

  // Pixel and line counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  // Lock state transitions. Nothing moves without a pixel strobe.
  always_comb begin
    state_d = state_q;
    if (pix_en_i) begin
      unique case (state_q)
        SEARCH: if (v_rise) state_d = ALIGN;
        // A dirty frame restarts alignment at the same edge, without a report.
        ALIGN:  if (v_rise && !frame_err_q && !viol) state_d = LOCKED;
        // A violation wins over a simultaneous vsync edge.
        LOCKED: if (viol) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Per-sample decisions: frame-clean tracking, frame counting, error reporting.
  always_comb begin
    frame_err_d = frame_err_q;
    frame_inc   = 1'b0;
    report      = 1'b0;
    if (pix_en_i) begin
      unique case (state_q)
        SEARCH: if (v_rise) frame_err_d = 1'b0;
        ALIGN: begin
          if (v_rise) begin
            frame_inc   = !frame_err_q && !viol;
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = frame_err_q | viol;
          end
        end
        LOCKED: begin
          report      = viol;
          frame_inc   = v_rise && !viol;
          frame_err_d = 1'b0;
        end
        default: frame_err_d = 1'b0;
      endcase
    end
  end

  // Registered outputs. Error pulses clear on every cycle that does not report.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= frame_err_d;
      locked_q    <= (state_d == LOCKED);
      h_err_q     <= report & h_viol;
      v_err_q     <= report & v_viol;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (report && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign locked_o    = locked_q;
  assign h_err_o     = h_err_q;
  assign v_err_o     = v_err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
